line_buffer_scheduler: RTL and testbench

//  Sequences the double line buffer between the pixel renderer (writer) and VGA scanout (reader).

---
 rtl/line_buffer_scheduler_pkg.sv | 39 +++
 rtl/line_buffer_scheduler_fill_counter.sv | 36 +++
 rtl/line_buffer_scheduler.sv | 133 +++++++++++++
 tb/tb_line_buffer_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/line_buffer_scheduler_pkg.sv
// Shared definitions for the line buffer scheduler: default geometry,
// a constant log2 helper, FSM state encoding and a saturating counter helper.
package line_buffer_scheduler_pkg;

  localparam int WIDTH_DEF      = 640;
  localparam int HEIGHT_DEF     = 480;
  localparam int PIXEL_SIZE_DEF = 8;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } lb_state_e;

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/line_buffer_scheduler_fill_counter.sv
// Pixel write-address counter for the back bank: clear, increment with
// wrap after the last pixel, and a terminal-count flag at WIDTH-1.
module line_fill_counter
  import line_buffer_scheduler_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [AW-1:0] count,
  output logic          at_last
);

  assign at_last = (count == AW'(WIDTH - 1));

  // Address register: clear wins over increment, wraps to 0 after the last pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      if (at_last) begin
        count <= '0;
      end else begin
        count <= count + AW'(1);
      end
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/line_buffer_scheduler.sv
// Double line buffer scheduler: grants renderer writes into the back bank,
// swaps banks on line_start when the back line is complete and flags
// underruns when the renderer has not finished the line in time.
module line_buffer_scheduler
  import line_buffer_scheduler_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int HEIGHT     = HEIGHT_DEF,
  parameter int PIXEL_SIZE = PIXEL_SIZE_DEF,
  parameter int AW         = clog2(WIDTH),
  parameter int LW         = clog2(HEIGHT) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  line_start,
  input  logic                  req,
  input  logic [PIXEL_SIZE-1:0] req_data,
  output logic                  gnt,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [PIXEL_SIZE-1:0] wr_data,
  output logic                  wr_bank,
  output logic                  rd_bank,
  output logic [LW-1:0]         fill_line,
  output logic [LW-1:0]         disp_line,
  output logic                  underrun,
  output logic [15:0]           underrun_cnt
);

  lb_state_e     state;
  logic          at_last;
  logic          clear;
  logic          final_write;
  logic [LW-1:0] next_fill;
  logic [LW-1:0] skip_disp;
  logic [LW-1:0] skip_fill;

  // Grant: only while filling; line/frame events block it except the
  // last pixel landing together with line_start, which completes the line.
  always_comb begin
    gnt = 1'b0;
    if (!reset && (state == ST_FILL) && !frame_start) begin
      if (line_start) begin
        gnt = req & at_last;
      end else begin
        gnt = req;
      end
    end else begin
      gnt = 1'b0;
    end
  end

  assign wr_en       = req & gnt;
  assign wr_data     = req_data;
  assign wr_bank     = ~rd_bank;
  assign final_write = wr_en & at_last;
  assign clear       = frame_start | (line_start & (state != ST_IDLE));
  assign next_fill   = fill_line + LW'(1);
  assign skip_disp   = disp_line + LW'(1);
  assign skip_fill   = disp_line + LW'(2);

  line_fill_counter #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_fill_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .inc     (wr_en),
    .count   (wr_addr),
    .at_last (at_last)
  );

  // Scheduler FSM with bank toggle, line counters and underrun tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      rd_bank      <= 1'b0;
      fill_line    <= '0;
      disp_line    <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= 16'd0;
    end else begin
      underrun <= 1'b0;
      if (frame_start) begin
        state     <= ST_FILL;
        fill_line <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_IDLE;
          end
          ST_FILL: begin
            if (line_start) begin
              if (final_write) begin
                rd_bank   <= ~rd_bank;
                disp_line <= fill_line;
                fill_line <= next_fill;
                state     <= (next_fill >= LW'(HEIGHT)) ? ST_IDLE : ST_FILL;
              end else begin
                // Stale line stays on screen; renderer skips ahead past it.
                underrun     <= 1'b1;
                underrun_cnt <= sat_inc16(underrun_cnt);
                disp_line    <= skip_disp;
                fill_line    <= skip_fill;
                state        <= (skip_fill >= LW'(HEIGHT)) ? ST_IDLE : ST_FILL;
              end
            end else if (final_write) begin
              state <= ST_FULL;
            end else begin
              state <= ST_FILL;
            end
          end
          ST_FULL: begin
            if (line_start) begin
              rd_bank   <= ~rd_bank;
              disp_line <= fill_line;
              fill_line <= next_fill;
              state     <= (next_fill >= LW'(HEIGHT)) ? ST_IDLE : ST_FILL;
            end else begin
              state <= ST_FULL;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Self-checking bench for line_buffer_scheduler (WIDTH=8, HEIGHT=4):
// table of per-cycle vectors plus a write scoreboard.
module tb_line_buffer_scheduler;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int PS = 8;
  localparam int AW = 3;
  localparam int LW = 3;

  logic          clk;
  logic          reset;
  logic          frame_start;
  logic          line_start;
  logic          req;
  logic [PS-1:0] req_data;
  logic          gnt;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [PS-1:0] wr_data;
  logic          wr_bank;
  logic          rd_bank;
  logic [LW-1:0] fill_line;
  logic [LW-1:0] disp_line;
  logic          underrun;
  logic [15:0]   underrun_cnt;

  line_buffer_scheduler #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .PIXEL_SIZE (PS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .line_start   (line_start),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_bank      (wr_bank),
    .rd_bank      (rd_bank),
    .fill_line    (fill_line),
    .disp_line    (disp_line),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          fs;
    logic          ls;
    logic          rq;
    logic [7:0]    data;
    logic          exp_gnt;
    logic          exp_rd;
    logic [LW-1:0] exp_fill;
    logic [LW-1:0] exp_disp;
    logic          exp_ur;
    logic [15:0]   exp_cnt;
    logic [AW-1:0] exp_addr;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          bank;
  } wr_t;

  vec_t tbl[$];
  wr_t  sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cur_row  = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s row=%0d got=%0h exp=%0h", name, cur_row, act, exp);
    end
  endtask

  task automatic ev(input logic rst, input logic fs, input logic ls, input logic rq,
                    input logic g, input logic rd, input logic [LW-1:0] fl,
                    input logic [LW-1:0] dl, input logic ur, input logic [15:0] cnt,
                    input logic [AW-1:0] ad);
    vec_t v;
    v.rst = rst; v.fs = fs; v.ls = ls; v.rq = rq;
    v.data = 8'($urandom_range(0, 255));
    v.exp_gnt = g; v.exp_rd = rd; v.exp_fill = fl; v.exp_disp = dl;
    v.exp_ur = ur; v.exp_cnt = cnt; v.exp_addr = ad;
    tbl.push_back(v);
  endtask

  // n granted pixels starting at address 0; the 8th write wraps the address to 0.
  task automatic fill(input int n, input logic [7:0] base, input logic rd,
                      input logic [LW-1:0] fl, input logic [LW-1:0] dl, input logic [15:0] cnt);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rst = 1'b0; v.fs = 1'b0; v.ls = 1'b0; v.rq = 1'b1;
      v.data = base + 8'(i);
      v.exp_gnt = 1'b1; v.exp_rd = rd; v.exp_fill = fl; v.exp_disp = dl;
      v.exp_ur = 1'b0; v.exp_cnt = cnt; v.exp_addr = AW'((i + 1) % W);
      tbl.push_back(v);
    end
  endtask

  // n cycles with req high but no grant expected (FULL or IDLE).
  task automatic hold(input int n, input logic rd, input logic [LW-1:0] fl,
                      input logic [LW-1:0] dl, input logic [15:0] cnt);
    for (int i = 0; i < n; i++) begin
      ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rd, fl, dl, 1'b0, cnt, 3'd0);
    end
  endtask

  initial begin
    logic [AW-1:0] cur_addr;
    logic          cur_rd;
    wr_t           got;
    wr_t           expw;

    // Normal frame: fill, 4 swaps spaced 12 cycles, then IDLE.
    ev(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 16'd0, 3'd0);
    fill(8, 8'h10, 1'b0, 3'd0, 3'd0, 16'd0);
    hold(2, 1'b0, 3'd0, 3'd0, 16'd0);
    ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 16'd0, 3'd0);
    fill(8, 8'h20, 1'b1, 3'd1, 3'd0, 16'd0);
    hold(3, 1'b1, 3'd1, 3'd0, 16'd0);
    ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 3'd1, 1'b0, 16'd0, 3'd0);
    fill(8, 8'h30, 1'b0, 3'd2, 3'd1, 16'd0);
    hold(3, 1'b0, 3'd2, 3'd1, 16'd0);
    ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 3'd2, 1'b0, 16'd0, 3'd0);
    fill(8, 8'h40, 1'b1, 3'd3, 3'd2, 16'd0);
    hold(3, 1'b1, 3'd3, 3'd2, 16'd0);
    ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 3'd3, 1'b0, 16'd0, 3'd0);
    hold(2, 1'b0, 3'd4, 3'd3, 16'd0);
    ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 3'd3, 1'b0, 16'd0, 3'd0);
    // New frame, then an underrun after only 5 pixels of line 1.
    ev(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd3, 1'b0, 16'd0, 3'd0);
    fill(8, 8'h50, 1'b0, 3'd0, 3'd3, 16'd0);
    ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 16'd0, 3'd0);
    fill(5, 8'h60, 1'b1, 3'd1, 3'd0, 16'd0);
    ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 3'd1, 1'b1, 16'd1, 3'd0);
    // Final pixel coincides with line_start: accepted and swapped.
    fill(7, 8'h70, 1'b1, 3'd2, 3'd1, 16'd1);
    ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 3'd2, 1'b0, 16'd1, 3'd0);
    // frame_start aborts a partial fill; then frame_start beats line_start.
    fill(3, 8'h80, 1'b0, 3'd3, 3'd2, 16'd1);
    ev(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd2, 1'b0, 16'd1, 3'd0);
    fill(2, 8'h90, 1'b0, 3'd0, 3'd2, 16'd1);
    ev(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd2, 1'b0, 16'd1, 3'd0);
    // Reset while FULL; line_start ignored until frame_start.
    fill(8, 8'hA0, 1'b0, 3'd0, 3'd2, 16'd1);
    ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 16'd0, 3'd0);
    ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 16'd0, 3'd0);
    hold(1, 1'b0, 3'd0, 3'd0, 16'd0);
    ev(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 16'd0, 3'd0);
    fill(2, 8'hB0, 1'b0, 3'd0, 3'd0, 16'd0);

    // Hand-written reset: 3 cycles high, then reset values.
    reset = 1'b1; frame_start = 1'b0; line_start = 1'b0; req = 1'b1; req_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rd_bank", 32'(rd_bank), 32'd0);
    chk("rst_wr_bank", 32'(wr_bank), 32'd1);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_fill_line", 32'(fill_line), 32'd0);
    chk("rst_disp_line", 32'(disp_line), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_underrun_cnt", 32'(underrun_cnt), 32'd0);

    cur_addr = '0;
    cur_rd   = 1'b0;
    for (int r = 0; r < tbl.size(); r++) begin
      cur_row     = r;
      reset       = tbl[r].rst;
      frame_start = tbl[r].fs;
      line_start  = tbl[r].ls;
      req         = tbl[r].rq;
      req_data    = tbl[r].data;
      if (tbl[r].rq && tbl[r].exp_gnt) begin
        expw.addr = cur_addr; expw.data = tbl[r].data; expw.bank = ~cur_rd;
        sb.push_back(expw);
      end
      #3;
      if (!tbl[r].rst) begin
        chk("gnt", 32'(gnt), 32'(tbl[r].exp_gnt));
      end
      if (wr_en) begin
        got.addr = wr_addr; got.data = wr_data; got.bank = wr_bank;
        if (sb.size() == 0) begin
          chk("unexpected_write", 32'(got), 32'hFFFF_FFFF);
        end else begin
          expw = sb.pop_front();
          chk("wr_addr_data_bank", 32'(got), 32'(expw));
        end
      end
      @(posedge clk);
      #1;
      chk("rd_bank", 32'(rd_bank), 32'(tbl[r].exp_rd));
      chk("fill_line", 32'(fill_line), 32'(tbl[r].exp_fill));
      chk("disp_line", 32'(disp_line), 32'(tbl[r].exp_disp));
      chk("underrun", 32'(underrun), 32'(tbl[r].exp_ur));
      chk("underrun_cnt", 32'(underrun_cnt), 32'(tbl[r].exp_cnt));
      chk("wr_addr_after", 32'(wr_addr), 32'(tbl[r].exp_addr));
      cur_addr = tbl[r].exp_addr;
      cur_rd   = tbl[r].exp_rd;
    end

    cur_row = -1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
